pe_result_to_blockfp: RTL and testbench

Converts the stream of per-PE floating-point results back into block floating point for the next layer. It collects up to `BLOCK_SIZE` results and finds their maximum exponent, which becomes the shared block exponent. Each result is then aligned to a signed `FEATURE_WIDTH`-bit mantissa, one element per cycle, and the block is presented as a single word on a valid/ready output. It sits between the PE array result drain and the feature write path.

---
 rtl/pe_result_to_blockfp_pkg.sv | 36 +++
 rtl/pe_result_to_blockfp_if.sv | 35 +++
 rtl/pe_result_to_blockfp_align.sv | 45 ++++
 rtl/pe_result_to_blockfp.sv | 143 ++++++++++++++
 tb/tb_pe_result_to_blockfp.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pe_result_to_blockfp_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pe_result_to_blockfp_pkg
// Brief   : Shared configuration type and helpers for the block-FP repacker.
// Revision: 1.0
// ============================================================================
package pe_result_to_blockfp_pkg;

    typedef struct packed {
        int RESULT_WIDTH;
        int RESULT_EXPONENT_WIDTH;
        int RESULT_MANTISSA_WIDTH;
        int RESULT_EXPONENT_BIAS;
        int EXPONENT_WIDTH;
        int EXPONENT_BIAS;
        int FEATURE_WIDTH;
    } pe_cfg_t;

    // fp16 results repacked into 8-bit block mantissas
    localparam pe_cfg_t PE_CFG_FP16_F8 = '{
        RESULT_WIDTH:          16,
        RESULT_EXPONENT_WIDTH: 5,
        RESULT_MANTISSA_WIDTH: 10,
        RESULT_EXPONENT_BIAS:  15,
        EXPONENT_WIDTH:        5,
        EXPONENT_BIAS:         15,
        FEATURE_WIDTH:         8
    };

    // Extra right shift that drops the fp mantissa onto the feature grid
    function automatic int blockfp_align_width(input pe_cfg_t cfg);
        return cfg.RESULT_MANTISSA_WIDTH - (cfg.FEATURE_WIDTH - 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pe_result_to_blockfp_if.sv
`default_nettype none
// ============================================================================
// Module  : pe_result_to_blockfp_if
// Brief   : Result-in / block-out handshake bundle for pe_result_to_blockfp.
// Revision: 1.0
// ============================================================================
interface pe_result_to_blockfp_if
    import pe_result_to_blockfp_pkg::*;
#(
    parameter pe_cfg_t cfg        = PE_CFG_FP16_F8,
    parameter int      BLOCK_SIZE = 8
);
    logic                                     i_valid;
    logic                                     i_ready;
    logic [cfg.RESULT_WIDTH-1:0]              i_result;
    logic                                     i_last;
    logic                                     o_valid;
    logic                                     o_ready;
    logic [cfg.EXPONENT_WIDTH-1:0]            o_exponent;
    logic [BLOCK_SIZE*cfg.FEATURE_WIDTH-1:0]  o_mantissa;
    logic [$clog2(BLOCK_SIZE+1)-1:0]          o_count;

    // master: result source and block sink; slave: the converter
    modport master (
        output i_valid, i_result, i_last, o_ready,
        input  i_ready, o_valid, o_exponent, o_mantissa, o_count
    );

    modport slave (
        input  i_valid, i_result, i_last, o_ready,
        output i_ready, o_valid, o_exponent, o_mantissa, o_count
    );

endinterface
`default_nettype wire

// File: rtl/pe_result_to_blockfp_align.sv
`default_nettype none
// ============================================================================
// Module  : pe_result_to_blockfp_align
// Brief   : Aligns one fp result to a signed mantissa under a shared exponent.
// Revision: 1.0
// ============================================================================
module pe_result_to_blockfp_align
    import pe_result_to_blockfp_pkg::*;
#(
    parameter pe_cfg_t cfg = PE_CFG_FP16_F8
)
(
    input  logic [cfg.RESULT_WIDTH-1:0]          i_result,
    input  logic [cfg.EXPONENT_WIDTH-1:0]        i_exponent,
    output logic signed [cfg.FEATURE_WIDTH-1:0]  o_mantissa
);

    localparam int c_rw = cfg.RESULT_WIDTH;
    localparam int c_ew = cfg.RESULT_EXPONENT_WIDTH;
    localparam int c_mw = cfg.RESULT_MANTISSA_WIDTH;
    localparam int c_fw = cfg.FEATURE_WIDTH;
    localparam int c_aw = blockfp_align_width(cfg);

    logic              w_sign;
    logic [c_ew-1:0]   w_exp;
    logic [c_mw:0]     w_sig;
    logic [c_ew:0]     w_d;
    logic [c_fw-2:0]   w_mag;

    assign w_sign = i_result[c_rw-1];
    assign w_exp  = i_result[c_mw +: c_ew];
    assign w_sig  = {1'b1, i_result[c_mw-1:0]};
    assign w_d    = {1'b0, i_exponent} - {1'b0, w_exp};
    assign w_mag  = (c_fw-1)'((w_sig >> w_d) >> c_aw);

    // Zero/denormal inputs flush; shifts past the hidden bit give zero
    always_comb begin
        o_mantissa = '0;
        if (w_exp != '0 && 32'(w_d) <= 32'(c_mw)) begin
            o_mantissa = w_sign ? -{1'b0, w_mag} : {1'b0, w_mag};
        end
    end

endmodule
`default_nettype wire

// File: rtl/pe_result_to_blockfp.sv
`default_nettype none
// ============================================================================
// Module  : pe_result_to_blockfp
// Brief   : Collects PE fp results into a block, then emits block-FP word.
// Revision: 1.0
// ============================================================================
module pe_result_to_blockfp
    import pe_result_to_blockfp_pkg::*;
#(
    parameter pe_cfg_t cfg        = PE_CFG_FP16_F8,
    parameter int      BLOCK_SIZE = 8
)
(
    input  logic                        clock,
    input  logic                        reset,
    pe_result_to_blockfp_if.slave       bus
);

    localparam int c_rw = cfg.RESULT_WIDTH;
    localparam int c_ew = cfg.EXPONENT_WIDTH;
    localparam int c_mw = cfg.RESULT_MANTISSA_WIDTH;
    localparam int c_fw = cfg.FEATURE_WIDTH;
    localparam int c_cw = $clog2(BLOCK_SIZE+1);
    localparam int c_kw = $clog2(BLOCK_SIZE);

    if (cfg.EXPONENT_WIDTH != cfg.RESULT_EXPONENT_WIDTH) begin : g_chk_exp_width
        $fatal(1, "pe_result_to_blockfp: EXPONENT_WIDTH != RESULT_EXPONENT_WIDTH");
    end
    if (cfg.EXPONENT_BIAS != cfg.RESULT_EXPONENT_BIAS) begin : g_chk_exp_bias
        $fatal(1, "pe_result_to_blockfp: EXPONENT_BIAS != RESULT_EXPONENT_BIAS");
    end
    if (cfg.FEATURE_WIDTH - 2 > cfg.RESULT_MANTISSA_WIDTH) begin : g_chk_feature_width
        $fatal(1, "pe_result_to_blockfp: FEATURE_WIDTH-2 > RESULT_MANTISSA_WIDTH");
    end
    if (BLOCK_SIZE < 2) begin : g_chk_block_size
        $fatal(1, "pe_result_to_blockfp: BLOCK_SIZE must be >= 2");
    end

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_CONVERT = 2'd1,
        ST_OUTPUT  = 2'd2
    } state_t;

    state_t                         r_state;
    logic [c_rw-1:0]                r_buf [BLOCK_SIZE];
    logic [c_cw-1:0]                r_count;
    logic [c_kw-1:0]                r_k;
    logic [c_ew-1:0]                r_max_exp;
    logic                           r_i_ready;
    logic                           r_o_valid;
    logic [c_ew-1:0]                r_o_exponent;
    logic [BLOCK_SIZE*c_fw-1:0]     r_o_mantissa;
    logic [c_cw-1:0]                r_o_count;

    logic                           w_accept;
    logic [c_ew-1:0]                w_in_exp;
    logic [c_cw-1:0]                w_count_next;
    logic signed [c_fw-1:0]         w_elem;

    assign w_accept     = (r_state == ST_COLLECT) && bus.i_valid;
    assign w_in_exp     = bus.i_result[c_mw +: c_ew];
    assign w_count_next = r_count + 1'b1;

    assign bus.i_ready    = r_i_ready;
    assign bus.o_valid    = r_o_valid;
    assign bus.o_exponent = r_o_exponent;
    assign bus.o_mantissa = r_o_mantissa;
    assign bus.o_count    = r_o_count;

    // Single aligner, walked across the buffer by r_k
    pe_result_to_blockfp_align #(
        .cfg        (cfg)
    ) u_align (
        .i_result   (r_buf[r_k]),
        .i_exponent (r_max_exp),
        .o_mantissa (w_elem)
    );

    // Buffer holds data only; stale slots beyond r_count are masked in CONVERT
    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_buf[r_count[c_kw-1:0]] <= bus.i_result;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= ST_COLLECT;
            r_count      <= '0;
            r_k          <= '0;
            r_max_exp    <= '0;
            r_i_ready    <= 1'b1;
            r_o_valid    <= 1'b0;
            r_o_exponent <= '0;
            r_o_mantissa <= '0;
            r_o_count    <= '0;
        end else begin
            case (r_state)
                ST_COLLECT: begin
                    if (w_accept) begin
                        r_count <= w_count_next;
                        if (w_in_exp > r_max_exp) begin
                            r_max_exp <= w_in_exp;
                        end
                        if (bus.i_last || w_count_next == c_cw'(BLOCK_SIZE)) begin
                            r_state   <= ST_CONVERT;
                            r_i_ready <= 1'b0;
                            r_k       <= '0;
                        end
                    end
                end
                ST_CONVERT: begin
                    r_o_mantissa[r_k*c_fw +: c_fw] <=
                        (c_cw'(r_k) < r_count) ? w_elem : '0;
                    if (r_k == c_kw'(BLOCK_SIZE-1)) begin
                        r_state      <= ST_OUTPUT;
                        r_o_valid    <= 1'b1;
                        r_o_exponent <= r_max_exp;
                        r_o_count    <= r_count;
                        r_k          <= '0;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                ST_OUTPUT: begin
                    if (bus.o_ready) begin
                        r_state   <= ST_COLLECT;
                        r_o_valid <= 1'b0;
                        r_i_ready <= 1'b1;
                        r_count   <= '0;
                        r_max_exp <= '0;
                    end
                end
                default: begin
                    r_state <= ST_COLLECT;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pe_result_to_blockfp.sv
`default_nettype none
// ============================================================================
// Module  : tb_pe_result_to_blockfp
// Brief   : Scoreboard bench for pe_result_to_blockfp (fp16 -> 4 x 8-bit).
// Revision: 1.0
// ============================================================================
module tb_pe_result_to_blockfp;
    import pe_result_to_blockfp_pkg::*;

    localparam pe_cfg_t C  = PE_CFG_FP16_F8;
    localparam int      BS = 4;

    typedef logic [15:0] blk_t [4];
    typedef struct {
        logic [4:0]  e;
        logic [31:0] m;
        logic [2:0]  c;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clock = ~clock;

    pe_result_to_blockfp_if #(.cfg(C), .BLOCK_SIZE(BS)) bus ();

    pe_result_to_blockfp #(.cfg(C), .BLOCK_SIZE(BS)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every block handshake
    always @(negedge clock) begin
        exp_t x;
        if (!reset && bus.o_valid && bus.o_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_block actual=%0h required=none", bus.o_mantissa);
            end else begin
                x = sb.pop_front();
                check("blk_exponent", 64'(bus.o_exponent), 64'(x.e));
                check("blk_mantissa", 64'(bus.o_mantissa), 64'(x.m));
                check("blk_count",    64'(bus.o_count),    64'(x.c));
            end
        end
    end

    function automatic exp_t model(input blk_t w, input int n);
        exp_t x;
        int   emax;
        int   e;
        int   d;
        int   mag;
        emax = 0;
        for (int i = 0; i < n; i++) begin
            if (int'(w[i][14:10]) > emax) emax = int'(w[i][14:10]);
        end
        x.e = 5'(emax);
        x.c = 3'(n);
        x.m = '0;
        for (int i = 0; i < n; i++) begin
            e = int'(w[i][14:10]);
            if (e != 0) begin
                d   = emax - e;
                mag = (d > 10) ? 0 : (1024 + int'(w[i][9:0])) / (1 << (d + 4));
                if (w[i][15]) mag = -mag;
                x.m[i*8 +: 8] = 8'(mag);
            end
        end
        return x;
    endfunction

    task automatic send(input blk_t w, input int n, input bit last);
        int guard;
        for (int i = 0; i < n; i++) begin
            guard        = 0;
            bus.i_valid  = 1'b1;
            bus.i_result = w[i];
            bus.i_last   = last && (i == n - 1);
            @(negedge clock);
            while (!bus.i_ready && guard < 50) begin
                guard++;
                @(negedge clock);
            end
            if (!bus.i_ready) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout actual=0 required=1");
            end
            @(posedge clock);
            #1;
        end
        bus.i_valid = 1'b0;
        bus.i_last  = 1'b0;
    endtask

    // Edges from the last accept until o_valid is seen high
    task automatic wait_valid(output int lat);
        lat = 0;
        @(negedge clock);
        while (!bus.o_valid && lat < 20) begin
            lat++;
            @(negedge clock);
        end
    endtask

    task automatic run_block(input blk_t w, input int n, input bit last,
                             input logic [4:0] e, input logic [31:0] m, input logic [2:0] c);
        int   lat;
        exp_t x;
        x.e = e;
        x.m = m;
        x.c = c;
        sb.push_back(x);
        bus.o_ready = 1'b1;
        send(w, n, last);
        wait_valid(lat);
        check("valid_latency", 64'(lat), 64'(BS));
        @(posedge clock);
        #1;
        check("post_hs_valid", 64'(bus.o_valid), 64'(0));
        check("post_hs_ready", 64'(bus.i_ready), 64'(1));
    endtask

    initial begin
        int   lat;
        int   n;
        bit   last;
        blk_t w;
        exp_t x;

        bus.i_valid  = 1'b0;
        bus.i_result = '0;
        bus.i_last   = 1'b0;
        bus.o_ready  = 1'b0;

        repeat (3) @(posedge clock);
        #1;
        check("rst_i_ready",    64'(bus.i_ready),    64'(1));
        check("rst_o_valid",    64'(bus.o_valid),    64'(0));
        check("rst_o_exponent", 64'(bus.o_exponent), 64'(0));
        check("rst_o_mantissa", 64'(bus.o_mantissa), 64'(0));
        check("rst_o_count",    64'(bus.o_count),    64'(0));
        reset = 1'b0;
        @(posedge clock);
        #1;

        w = '{16'h3C00, 16'h3800, 16'hBE00, 16'h0000};
        run_block(w, 4, 1'b0, 5'd15, 32'h00A0_2040, 3'd4);

        w = '{16'h3C00, 16'h1400, 16'h1000, 16'h17FF};
        run_block(w, 4, 1'b0, 5'd15, 32'h0000_0040, 3'd4);

        w = '{16'h4000, 16'hC000, 16'h0000, 16'h0000};
        run_block(w, 2, 1'b1, 5'd16, 32'h0000_C040, 3'd2);

        w = '{16'h7C00, 16'h7BFF, 16'h0001, 16'hFC00};
        run_block(w, 4, 1'b1, 5'd31, 32'hC000_3F40, 3'd4);

        w = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
        run_block(w, 4, 1'b0, 5'd0, 32'h0000_0000, 3'd4);

        // Back-pressure: block must sit stable while o_ready is low
        w   = '{16'h4400, 16'h3C00, 16'h3400, 16'hC200};
        x.e = 5'd17;
        x.m = 32'hD004_1040;
        x.c = 3'd4;
        sb.push_back(x);
        bus.o_ready = 1'b0;
        send(w, 4, 1'b0);
        wait_valid(lat);
        check("hold_latency", 64'(lat), 64'(BS));
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("hold_o_valid",    64'(bus.o_valid),    64'(1));
            check("hold_i_ready",    64'(bus.i_ready),    64'(0));
            check("hold_o_exponent", 64'(bus.o_exponent), 64'(17));
            check("hold_o_mantissa", 64'(bus.o_mantissa), 64'h0000_0000_D004_1040);
        end
        @(posedge clock);
        #1;
        bus.o_ready = 1'b1;
        @(posedge clock);
        #1;

        w = '{16'h3000, 16'h0000, 16'h0000, 16'h0000};
        run_block(w, 1, 1'b1, 5'd12, 32'h0000_0040, 3'd1);

        // Reset in CONVERT drops the partial block
        w = '{16'h4800, 16'h4800, 16'h4800, 16'h4800};
        bus.o_ready = 1'b1;
        send(w, 4, 1'b0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("rst_conv_o_valid", 64'(bus.o_valid), 64'(0));
        check("rst_conv_i_ready", 64'(bus.i_ready), 64'(1));
        check("rst_conv_o_count", 64'(bus.o_count), 64'(0));
        @(posedge clock);
        #1;
        reset = 1'b0;
        w = '{16'h3800, 16'h0000, 16'h0000, 16'h0000};
        run_block(w, 1, 1'b1, 5'd14, 32'h0000_0040, 3'd1);

        // Reset in OUTPUT
        w = '{16'h4800, 16'h4800, 16'h4800, 16'h4800};
        bus.o_ready = 1'b0;
        send(w, 4, 1'b0);
        wait_valid(lat);
        check("rst_out_latency", 64'(lat), 64'(BS));
        #2;
        reset = 1'b1;
        #1;
        check("rst_out_o_valid",    64'(bus.o_valid),    64'(0));
        check("rst_out_i_ready",    64'(bus.i_ready),    64'(1));
        check("rst_out_o_mantissa", 64'(bus.o_mantissa), 64'(0));
        @(posedge clock);
        #1;
        reset = 1'b0;
        w = '{16'h3400, 16'h3800, 16'h0000, 16'h0000};
        run_block(w, 2, 1'b1, 5'd14, 32'h0000_4020, 3'd2);

        for (int r = 0; r < 8; r++) begin
            n = int'($urandom_range(1, 4));
            last = (n < 4) ? 1'b1 : 1'($urandom_range(0, 1));
            for (int i = 0; i < 4; i++) w[i] = 16'($urandom);
            x = model(w, n);
            run_block(w, n, last, x.e, x.m, x.c);
        end

        repeat (5) @(posedge clock);
        check("scoreboard_empty", 64'(sb.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
